// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared constants and helpers for the whack event generator
package whack_pkg;

    localparam int         N_HOLES_DEFAULT = 4;
    localparam int         HOLE_IDX_W      = 3;
    localparam logic [7:0] GAME_RUNNING    = 8'd0;

    // Index of the lowest set bit; 0 when no bit is set (callers gate with |v).
    function automatic logic [HOLE_IDX_W-1:0] lowest_set(input logic [7:0] v);
        logic [HOLE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = HOLE_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus stable-count debouncer for one button
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  synchronous active-low reset
//   btn    in  1  raw asynchronous button level
//   level  out 1  debounced level
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            // Any cycle agreeing with the current level restarts the count, so
            // a bounce must be quiet for the full window before it is accepted.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/whack_event_gen.sv
// rtl/whack_event_gen.sv - turns hole buttons into whacked/miss pulses and retract requests
//
// Ports:
//   clk         in  1           system clock
//   rst_n       in  1           synchronous active-low reset
//   btn         in  N_HOLES     raw buttons, 1 = pressed
//   mole_mask   in  N_HOLES     moles currently up
//   game_count  in  8           countdown; 0 = game running
//   whacked     out 1           1-cycle pulse, press on a hole with a mole up
//   miss        out 1           1-cycle pulse, press on an empty (or locked) hole
//   hit_idx     out HOLE_IDX_W  hole of the latest event, held between events
//   mole_clear  out N_HOLES     1-cycle one-hot retract request alongside whacked
module whack_event_gen
    import whack_pkg::*;
#(
    parameter int N_HOLES         = N_HOLES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_HOLES-1:0]    btn,
    input  logic [N_HOLES-1:0]    mole_mask,
    input  logic [7:0]            game_count,
    output logic                  whacked,
    output logic                  miss,
    output logic [HOLE_IDX_W-1:0] hit_idx,
    output logic [N_HOLES-1:0]    mole_clear
);

    logic [N_HOLES-1:0]    deb;
    logic [N_HOLES-1:0]    deb_q;
    logic [N_HOLES-1:0]    rise;
    logic [N_HOLES-1:0]    pending;
    logic [N_HOLES-1:0]    lockout;

    logic [7:0]            pend8;
    logic                  svc_any;
    logic [HOLE_IDX_W-1:0] svc_idx;
    logic [N_HOLES-1:0]    svc_onehot;
    logic                  svc_hit;
    logic                  running;

    for (genvar g = 0; g < N_HOLES; g++) begin : g_hole
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[g]),
            .level(deb[g])
        );
    end

    assign rise = deb & ~deb_q;

    always_comb begin
        pend8              = '0;
        pend8[N_HOLES-1:0] = pending;
        running            = (game_count == GAME_RUNNING);
        svc_any            = |pending;
        svc_idx            = lowest_set(pend8);
        svc_onehot         = svc_any ? (N_HOLES'(1) << svc_idx) : '0;
        // A locked hole already scored its current mole, so pressing it again is a miss.
        svc_hit            = |(svc_onehot & mole_mask & ~lockout);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_q      <= '0;
            pending    <= '0;
            lockout    <= '0;
            whacked    <= 1'b0;
            miss       <= 1'b0;
            hit_idx    <= '0;
            mole_clear <= '0;
        end else begin
            deb_q      <= deb;
            whacked    <= 1'b0;
            miss       <= 1'b0;
            mole_clear <= '0;
            // Lockout lives until the mole retracts; the debouncers and edge
            // register keep running outside the game so a held button only
            // counts after a release and re-press.
            lockout    <= (lockout & mole_mask) |
                          ((running && svc_hit) ? svc_onehot : '0);
            if (!running) begin
                pending <= '0;
            end else begin
                // A press arriving while its bit is still pending merges into it.
                pending <= (pending | rise) & ~svc_onehot;
                if (svc_any) begin
                    hit_idx <= svc_idx;
                    if (svc_hit) begin
                        whacked    <= 1'b1;
                        mole_clear <= svc_onehot;
                    end else begin
                        miss <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
